// File: rtl/inv_arbiter.sv
// Round-robin front end that shares one modular-division unit (a/b mod n) between
// N_REQ requesters, screening out b==0 before the unit is started.
module inv_arbiter #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_n,
    input  logic [N_REQ*WIDTH-1:0] i_a,
    input  logic [N_REQ*WIDTH-1:0] i_b,
    output logic [N_REQ-1:0]       o_ack,
    output logic [WIDTH-1:0]       o_result,
    output logic                   o_err,
    output logic [ID_W-1:0]        o_grant_id,
    output logic                   o_busy,
    output logic                   o_inv_start,
    output logic [WIDTH-1:0]       o_inv_n,
    output logic [WIDTH-1:0]       o_inv_a,
    output logic [WIDTH-1:0]       o_inv_b,
    input  logic [WIDTH-1:0]       i_inv_result,
    input  logic                   i_inv_finished
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [ID_W:0]  NReqW   = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LastId = ID_W'(N_REQ - 1);

    state_e state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;

    // ------------------------------------------------------------------
    // Round-robin pick: rotate requests so the rr pointer sits at bit 0,
    // take the lowest set bit, then rotate the offset back.
    // ------------------------------------------------------------------
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               any_req;
    logic [ID_W-1:0]    pick_off;
    logic [ID_W:0]      pick_sum;
    logic [ID_W-1:0]    pick;
    logic [WIDTH-1:0]   sel_n, sel_a, sel_b;
    logic               sel_b_zero;

    assign req_dbl = {i_req, i_req};
    assign req_rot = N_REQ'(req_dbl >> rr_q);
    assign any_req = |i_req;

    always_comb begin
        pick_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_off = ID_W'(i);
            end
        end
        pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
        if (pick_sum >= NReqW) begin
            pick_sum = pick_sum - NReqW;
        end
        pick = pick_sum[ID_W-1:0];
    end

    assign sel_n      = i_n[pick*WIDTH +: WIDTH];
    assign sel_a      = i_a[pick*WIDTH +: WIDTH];
    assign sel_b      = i_b[pick*WIDTH +: WIDTH];
    assign sel_b_zero = (sel_b == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = sel_b_zero ? StResp : StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (i_inv_finished) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values; every output is registered so the
    // ack, start and result change only on clock edges.
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] ack_d;
    logic [WIDTH-1:0] result_d;
    logic             err_d;
    logic [ID_W-1:0]  grant_d;
    logic             start_d;
    logic [WIDTH-1:0] inv_n_d, inv_a_d, inv_b_d;

    always_comb begin
        ack_d    = '0;
        result_d = o_result;
        err_d    = o_err;
        grant_d  = o_grant_id;
        start_d  = 1'b0;
        inv_n_d  = o_inv_n;
        inv_a_d  = o_inv_a;
        inv_b_d  = o_inv_b;
        rr_d     = rr_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = pick;
                    inv_n_d = sel_n;
                    inv_a_d = sel_a;
                    inv_b_d = sel_b;
                    if (sel_b_zero) begin
                        // The unit would silently return n for b==0.
                        ack_d    = N_REQ'(1) << pick;
                        result_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        start_d = 1'b1;
                    end
                end
            end
            StIssue: ;
            StWait: begin
                if (i_inv_finished) begin
                    ack_d    = N_REQ'(1) << o_grant_id;
                    result_d = i_inv_result;
                    err_d    = 1'b0;
                end
            end
            StResp: begin
                rr_d = (o_grant_id == LastId) ? '0 : o_grant_id + ID_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_q        <= '0;
            o_ack       <= '0;
            o_result    <= '0;
            o_err       <= 1'b0;
            o_grant_id  <= '0;
            o_busy      <= 1'b0;
            o_inv_start <= 1'b0;
            o_inv_n     <= '0;
            o_inv_a     <= '0;
            o_inv_b     <= '0;
        end else begin
            rr_q        <= rr_d;
            o_ack       <= ack_d;
            o_result    <= result_d;
            o_err       <= err_d;
            o_grant_id  <= grant_d;
            o_busy      <= (state_d != StIdle);
            o_inv_start <= start_d;
            o_inv_n     <= inv_n_d;
            o_inv_a     <= inv_a_d;
            o_inv_b     <= inv_b_d;
        end
    end

endmodule

// File: tb/tb_inv_arbiter.sv
// Directed self-checking bench for inv_arbiter with a small behavioural division unit.
module tb_inv_arbiter;

    localparam int unsigned W = 32;
    localparam int unsigned N = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_n, req_a, req_b;
    logic [N-1:0]   o_ack;
    logic [W-1:0]   o_result;
    logic           o_err;
    logic [0:0]     o_grant_id;
    logic           o_busy;
    logic           o_inv_start;
    logic [W-1:0]   o_inv_n, o_inv_a, o_inv_b;
    logic [W-1:0]   u_res;
    logic           fin_model;
    logic           fin_inj;
    wire            inv_finished = fin_model | fin_inj;

    int checks = 0;
    int passes = 0;
    int start_cnt = 0;

    inv_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(1)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_n           (req_n),
        .i_a           (req_a),
        .i_b           (req_b),
        .o_ack         (o_ack),
        .o_result      (o_result),
        .o_err         (o_err),
        .o_grant_id    (o_grant_id),
        .o_busy        (o_busy),
        .o_inv_start   (o_inv_start),
        .o_inv_n       (o_inv_n),
        .o_inv_a       (o_inv_a),
        .o_inv_b       (o_inv_b),
        .i_inv_result  (u_res),
        .i_inv_finished(inv_finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Brute-force a/b mod n for the small moduli used here.
    function automatic logic [W-1:0] div_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] n);
        longint unsigned q;
        for (q = 0; q < longint'(n); q++) begin
            if ((q * longint'(b)) % longint'(n) == longint'(a) % longint'(n)) return W'(q);
        end
        return '0;
    endfunction

    // Behavioural division unit: finishes a few cycles after start.
    logic       u_busy;
    logic [3:0] u_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            u_busy    <= 1'b0;
            u_cnt     <= '0;
            fin_model <= 1'b0;
            u_res     <= '0;
        end else begin
            fin_model <= 1'b0;
            if (o_inv_start) begin
                u_busy <= 1'b1;
                u_cnt  <= 4'd2;
                u_res  <= div_mod(o_inv_a, o_inv_b, o_inv_n);
            end else if (u_busy) begin
                if (u_cnt == 0) begin
                    fin_model <= 1'b1;
                    u_busy    <= 1'b0;
                end else begin
                    u_cnt <= u_cnt - 1'b1;
                end
            end
        end
    end

    always @(posedge clk) if (o_inv_start) start_cnt <= start_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input logic [W-1:0] n, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        req_n[k*W +: W] = n;
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
    endtask

    task automatic wait_ack(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            seen = (o_ack != '0);
        end
    endtask

    task automatic do_reset();
        req = '0;
        fin_inj = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = '0; req_n = '0; req_a = '0; req_b = '0; fin_inj = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (o_ack !== 2'b00 || o_busy !== 1'b0 || o_inv_start !== 1'b0)
            $display("FAIL reset_ctrl: got ack=%b busy=%b start=%b required 00/0/0",
                     o_ack, o_busy, o_inv_start);
        else passes++;
        checks++;
        if (o_result !== '0 || o_err !== 1'b0 || o_grant_id !== 1'b0)
            $display("FAIL reset_result: got result=%0d err=%b grant=%0d required 0/0/0",
                     o_result, o_err, o_grant_id);
        else passes++;
        checks++;
        if (o_inv_n !== '0 || o_inv_a !== '0 || o_inv_b !== '0)
            $display("FAIL reset_operands: got n=%0d a=%0d b=%0d required 0/0/0",
                     o_inv_n, o_inv_a, o_inv_b);
        else passes++;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic_req0();
        int s0;
        bit seen;
        s0 = start_cnt;
        set_slot(0, 17, 1, 3);
        req = 2'b01;
        tick();
        checks++;
        if (o_inv_start !== 1'b1 || o_busy !== 1'b1 || o_grant_id !== 1'b0)
            $display("FAIL basic_issue: got start=%b busy=%b grant=%0d required 1/1/0",
                     o_inv_start, o_busy, o_grant_id);
        else passes++;
        checks++;
        if (o_inv_n !== 32'd17 || o_inv_a !== 32'd1 || o_inv_b !== 32'd3)
            $display("FAIL basic_latch: got n=%0d a=%0d b=%0d required 17/1/3",
                     o_inv_n, o_inv_a, o_inv_b);
        else passes++;
        tick();
        checks++;
        if (o_inv_start !== 1'b0)
            $display("FAIL basic_start_width: got start=%b required 0", o_inv_start);
        else passes++;
        wait_ack(30, seen);
        checks++;
        if (!seen) $display("FAIL basic_ack_timeout: got no ack required ack within 30 cycles");
        else passes++;
        checks++;
        if (o_ack !== 2'b01 || o_result !== 32'd6 || o_err !== 1'b0)
            $display("FAIL basic_resp: got ack=%b result=%0d err=%b required 01/6/0",
                     o_ack, o_result, o_err);
        else passes++;
        checks++;
        if (o_inv_b !== 32'd3 || o_grant_id !== 1'b0)
            $display("FAIL basic_hold: got b=%0d grant=%0d required 3/0", o_inv_b, o_grant_id);
        else passes++;
        req = '0;
        tick();
        checks++;
        if (o_ack !== 2'b00 || o_busy !== 1'b0 || start_cnt - s0 != 1)
            $display("FAIL basic_after: got ack=%b busy=%b starts=%0d required 00/0/1",
                     o_ack, o_busy, start_cnt - s0);
        else passes++;
    endtask

    task automatic test_req1();
        bit seen;
        bit busy_low;
        set_slot(1, 17, 5, 3);
        req = 2'b10;
        tick();
        checks++;
        if (o_inv_start !== 1'b1 || o_grant_id !== 1'b1)
            $display("FAIL req1_issue: got start=%b grant=%0d required 1/1", o_inv_start, o_grant_id);
        else passes++;
        busy_low = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (o_busy !== 1'b1) busy_low = 1'b1;
            tick();
            seen = (o_ack != '0);
        end
        checks++;
        if (!seen || busy_low || o_busy !== 1'b1)
            $display("FAIL req1_busy: got seen=%b busy_dropped=%b busy_at_ack=%b required 1/0/1",
                     seen, busy_low, o_busy);
        else passes++;
        checks++;
        if (o_ack !== 2'b10 || o_result !== 32'd13 || o_err !== 1'b0)
            $display("FAIL req1_resp: got ack=%b result=%0d err=%b required 10/13/0",
                     o_ack, o_result, o_err);
        else passes++;
        req = '0;
        tick();
        checks++;
        if (o_busy !== 1'b0) $display("FAIL req1_idle: got busy=%b required 0", o_busy);
        else passes++;
    endtask

    task automatic test_div_zero();
        int s0;
        s0 = start_cnt;
        set_slot(0, 17, 4, 0);
        req = 2'b01;
        tick();
        checks++;
        if (o_ack !== 2'b01 || o_err !== 1'b1 || o_result !== '0 || o_inv_start !== 1'b0)
            $display("FAIL divzero_resp: got ack=%b err=%b result=%0d start=%b required 01/1/0/0",
                     o_ack, o_err, o_result, o_inv_start);
        else passes++;
        req = '0;
        tick();
        tick();
        checks++;
        if (o_ack !== 2'b00 || start_cnt != s0)
            $display("FAIL divzero_nostart: got ack=%b starts=%0d required 00/0",
                     o_ack, start_cnt - s0);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int s0;
        bit seen;
        logic [N-1:0]  exp_ack [4];
        logic [W-1:0]  exp_res [4];
        exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_res = '{32'd6, 32'd13, 32'd6, 32'd13};
        set_slot(0, 17, 1, 3);
        set_slot(1, 17, 5, 3);
        rst = 1'b1;
        req = 2'b11;
        tick();
        s0 = start_cnt;
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            wait_ack(30, seen);
            checks++;
            if (!seen || o_ack !== exp_ack[t] || o_result !== exp_res[t])
                $display("FAIL b2b_txn%0d: got seen=%b ack=%b result=%0d required 1/%b/%0d",
                         t, seen, o_ack, o_result, exp_ack[t], exp_res[t]);
            else passes++;
            if (t == 3) req = '0;
            tick();
            checks++;
            if (o_ack !== 2'b00 || o_inv_start !== 1'b0 || o_busy !== 1'b0)
                $display("FAIL b2b_gap%0d: got ack=%b start=%b busy=%b required 00/0/0",
                         t, o_ack, o_inv_start, o_busy);
            else passes++;
        end
        checks++;
        if (start_cnt - s0 != 4)
            $display("FAIL b2b_starts: got %0d required 4", start_cnt - s0);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        set_slot(0, 17, 1, 3);
        req = 2'b01;
        tick();
        tick();
        tick();
        checks++;
        if (o_busy !== 1'b1) $display("FAIL rstmid_pre: got busy=%b required 1", o_busy);
        else passes++;
        rst = 1'b1;
        req = '0;
        #1;
        checks++;
        if (o_ack !== '0 || o_busy !== 1'b0 || o_inv_start !== 1'b0 || o_result !== '0 ||
            o_inv_a !== '0 || o_inv_n !== '0 || o_inv_b !== '0 || o_err !== 1'b0)
            $display("FAIL rstmid_clear: got ack=%b busy=%b result=%0d a=%0d required all 0",
                     o_ack, o_busy, o_result, o_inv_a);
        else passes++;
        tick();
        tick();
        rst = 1'b0;
        fin_inj = 1'b1;
        tick();
        fin_inj = 1'b0;
        tick();
        tick();
        checks++;
        if (o_ack !== '0 || o_busy !== 1'b0 || o_result !== '0)
            $display("FAIL rstmid_spurious: got ack=%b busy=%b result=%0d required 00/0/0",
                     o_ack, o_busy, o_result);
        else passes++;
        req = 2'b01;
        wait_ack(30, seen);
        checks++;
        if (!seen || o_ack !== 2'b01 || o_result !== 32'd6)
            $display("FAIL rstmid_rereq: got seen=%b ack=%b result=%0d required 1/01/6",
                     seen, o_ack, o_result);
        else passes++;
        req = '0;
        tick();
    endtask

    task automatic test_drop_after_grant();
        bit seen;
        int acks;
        set_slot(0, 17, 5, 3);
        req = 2'b01;
        tick();
        tick();
        req = '0;
        wait_ack(30, seen);
        checks++;
        if (!seen || o_ack !== 2'b01 || o_result !== 32'd13)
            $display("FAIL drop_resp: got seen=%b ack=%b result=%0d required 1/01/13",
                     seen, o_ack, o_result);
        else passes++;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) fin_inj = 1'b1;
            if (i == 3) fin_inj = 1'b0;
            tick();
            if (o_ack != '0 || o_busy) acks++;
        end
        checks++;
        if (acks != 0)
            $display("FAIL drop_single_ack: got %0d extra active cycles required 0", acks);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_req0();
        test_req1();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_drop_after_grant();
        do_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inv_arbiter.md
Name: inv_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one modular-division unit (result = a/b mod n, binary-inversion datapath) between N_REQ requesters, e.g. point-add and point-double controllers.
- Latches the winner's operands and issues a one-cycle start to the unit. Waits for the unit's finished pulse, then returns the result with a one-cycle ack to the granted requester.
- Screens out b==0, which the unit cannot detect: it would return n.

Parameters:
- WIDTH, 256, operand/result width.
- N_REQ, 2, number of requesters (2..4).
- ID_W, 1, width of grant index; must hold N_REQ-1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_req  in  N_REQ  per-requester request level.
- i_n  in  N_REQ*WIDTH  moduli; slot k = bits [k*WIDTH +: WIDTH].
- i_a  in  N_REQ*WIDTH  dividends, same slotting.
- i_b  in  N_REQ*WIDTH  divisors, same slotting.
- o_ack  out  N_REQ  one-hot, one-cycle completion strobe.
- o_result  out  WIDTH  quotient, valid while any o_ack bit is high.
- o_err  out  1  divide-by-zero flag, valid with o_ack.
- o_grant_id  out  ID_W  index of the current/last granted requester.
- o_busy  out  1  high in any state other than IDLE.
- o_inv_start  out  1  start pulse to the division unit.
- o_inv_n  out  WIDTH  latched modulus to the unit.
- o_inv_a  out  WIDTH  latched dividend to the unit.
- o_inv_b  out  WIDTH  latched divisor to the unit.
- i_inv_result  in  WIDTH  unit result.
- i_inv_finished  in  1  unit one-cycle done pulse.

Behaviour:
- Reset (async, i_rst=1): state IDLE, rr pointer 0, o_ack=0, o_result=0, o_err=0, o_grant_id=0, o_busy=0, o_inv_start=0, o_inv_n/a/b=0.
- The unit has its own active-low reset; integration drives it with ~i_rst, so both reset together.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any i_req bit is set, grant the first set bit searching from the rr pointer upward, with wrap.
  - Latch that slot's n/a/b into o_inv_n/a/b and set o_grant_id.
  - If the slot's b==0: set err_r=1, result_r=0, go RESP, and do not start the unit.
  - Otherwise go ISSUE.
- ISSUE: o_inv_start=1 for exactly this cycle; next state WAIT.
- WAIT:
  - On i_inv_finished=1, capture i_inv_result into result_r, clear err_r, go RESP.
  - i_inv_finished outside WAIT is ignored.
- RESP:
  - o_ack[o_grant_id]=1 for one cycle, with o_result=result_r and o_err=err_r.
  - rr pointer becomes o_grant_id+1, wrapping at N_REQ.
  - Next state IDLE.
- Registered outputs: o_ack, o_result, o_err, o_inv_start; o_busy is registered from the state.
- Latency, req sampled in IDLE at edge 0:
  - start high in cycle 1.
  - ack in the cycle after finished is sampled.
  - b==0 case: ack in cycle 1.
- o_inv_n/a/b are held constant from ISSUE through RESP. The unit samples operands only with start, but holding them is still required.
- Requester handshake:
  - Requesters hold i_req and operands until ack. Operands are sampled only in IDLE.
  - An i_req drop after grant does not abort the operation; the ack is still issued.
  - A requester may re-assert in the ack cycle. It is eligible in the next IDLE but loses priority to others via the rr pointer.
- Simultaneous requests: exactly one grant per IDLE, per rr order. No starvation: a persistent requester is served within N_REQ transactions.
- Back-to-back: minimum one IDLE cycle between RESP and the next ISSUE.
- Reset mid-operation: everything returns to reset values immediately and no ack is issued. A pending i_inv_finished after reset release is ignored, since the arbiter is in IDLE.
- o_result keeps its last value outside ack cycles. Consumers use it only while o_ack is high.

Test Plan:
- req0 with n=17, a=1, b=3 -> one o_inv_start pulse, then o_ack=01, o_result=6, o_err=0, o_grant_id=0.
- req1 with n=17, a=5, b=3 -> o_ack=10, o_result=13 (3*13 mod 17 = 5), o_busy high from start through RESP.
- req0 with b=0, n=17 -> o_ack=01 in the cycle after grant, o_err=1, o_result=0, o_inv_start never asserted.
- req0 and req1 both asserted continuously from reset -> serviced in order 0,1,0,1 with exactly one start per transaction and no overlapping acks.
- i_rst pulsed while in WAIT (n=17, a=1, b=3) -> all outputs 0 immediately, no ack. A re-request after release completes with result 6.
- req0 deasserted one cycle after grant -> the operation still completes and o_ack[0] pulses once. Spurious i_inv_finished injected in IDLE -> no effect.
